// File: rtl/epu_dpcm_pkg.sv
// epu_dpcm_pkg: shared component tags, scheduler states and DC value types.
package epu_dpcm_pkg;
    localparam int DC_W = 12;
    localparam logic [1:0] MODE_Y = 2'b01;
    localparam logic [1:0] MODE_CR = 2'b10;
    localparam logic [1:0] MODE_CB = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN_Y, RUN_CB, RUN_CR} sched_state_t;
    typedef logic signed [DC_W-1:0] dc_t;
    typedef logic signed [DC_W:0] dc_diff_t;
endpackage

// File: rtl/dpcm_pred_bank.sv
// dpcm_pred_bank: three per-component DC predictors and the shared subtractor.
module dpcm_pred_bank #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    sel,
    input  logic [DW-1:0] dc,
    input  logic          upd,
    input  logic          clr,
    output logic [DW:0]   diff
);
    logic [DW-1:0] pred [3];
    logic [DW-1:0] cur;
    assign cur = sel == 2'd0 ? pred[0] : sel == 2'd1 ? pred[1] : pred[2];
    assign diff = {dc[DW-1], dc} - {cur[DW-1], cur};
    // clear wins over update so a restart on a Cr accept leaves all zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) pred[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (clr) pred[i] <= '0;
                else if (upd && sel == 2'(i)) pred[i] <= dc;
        end
    end
endmodule

// File: rtl/dpcm_dc_sched.sv
// dpcm_dc_sched: MCU-ordered Y/Cb/Cr DC scheduler feeding one DPCM datapath.
// Optional DPCM_RESTART_EN adds periodic predictor restarts and rst_marker.
module dpcm_dc_sched
    import epu_dpcm_pkg::*;
#(
    parameter int DW = 12,
    parameter int Y_PER_MCU = 4,
    parameter int NUM_MCU = 64
`ifdef DPCM_RESTART_EN
    ,
    parameter int RST_INTERVAL = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] y_dc,
    input  logic          y_valid,
    output logic          y_ready,
    input  logic [DW-1:0] cb_dc,
    input  logic          cb_valid,
    output logic          cb_ready,
    input  logic [DW-1:0] cr_dc,
    input  logic          cr_valid,
    output logic          cr_ready,
    output logic [DW:0]   dpcm_out,
    output logic [1:0]    dpcm_mode,
    output logic          dpcm_valid,
    input  logic          dpcm_ready,
    output logic          dpcm_last,
    output logic          busy
`ifdef DPCM_RESTART_EN
    ,
    output logic          rst_marker
`endif
);
    localparam int YW = Y_PER_MCU > 1 ? $clog2(Y_PER_MCU) : 1;
    localparam int MW = NUM_MCU > 1 ? $clog2(NUM_MCU) : 1;

    sched_state_t state, state_nx;
    logic [YW-1:0] y_cnt;
    logic [MW-1:0] mcu_cnt;
    logic room, acc, go, last_mcu, y_done, restart;
    logic [1:0] sel, tag;
    logic [DW-1:0] dc;
    logic [DW:0] diff;

    // the output register can take new data when empty or draining this cycle
    assign room = !dpcm_valid || dpcm_ready;
    assign y_ready = state == RUN_Y && room;
    assign cb_ready = state == RUN_CB && room;
    assign cr_ready = state == RUN_CR && room;
    assign acc = (y_ready && y_valid) || (cb_ready && cb_valid) || (cr_ready && cr_valid);
    assign go = state == IDLE && start;
    assign last_mcu = mcu_cnt == MW'(NUM_MCU - 1);
    assign y_done = y_cnt == YW'(Y_PER_MCU - 1);
    assign sel = state == RUN_CB ? 2'd1 : state == RUN_CR ? 2'd2 : 2'd0;
    assign tag = state == RUN_CB ? MODE_CB : state == RUN_CR ? MODE_CR : MODE_Y;
    assign dc = state == RUN_CB ? cb_dc : state == RUN_CR ? cr_dc : y_dc;
    assign busy = state != IDLE;
`ifdef DPCM_RESTART_EN
    assign restart = state == RUN_CR && acc && !last_mcu
                     && ((int'(mcu_cnt) + 1) % RST_INTERVAL) == 0;
`else
    assign restart = 1'b0;
`endif

    dpcm_pred_bank #(.DW(DW)) u_pred (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .dc(dc),
        .upd(acc),
        .clr(go || restart),
        .diff(diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN_Y : IDLE;
            RUN_Y:   state_nx = acc && y_done ? RUN_CB : RUN_Y;
            RUN_CB:  state_nx = acc ? RUN_CR : RUN_CB;
            RUN_CR:  state_nx = acc ? (last_mcu ? IDLE : RUN_Y) : RUN_CR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_cnt <= '0;
            mcu_cnt <= '0;
        end else if (go) begin
            y_cnt <= '0;
            mcu_cnt <= '0;
        end else if (acc) begin
            if (state == RUN_Y) y_cnt <= y_done ? '0 : y_cnt + 1'b1;
            if (state == RUN_CR) mcu_cnt <= mcu_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpcm_out <= '0;
            dpcm_mode <= '0;
            dpcm_valid <= 1'b0;
            dpcm_last <= 1'b0;
`ifdef DPCM_RESTART_EN
            rst_marker <= 1'b0;
`endif
        end else if (acc) begin
            dpcm_out <= diff;
            dpcm_mode <= tag;
            dpcm_valid <= 1'b1;
            dpcm_last <= state == RUN_CR && last_mcu;
`ifdef DPCM_RESTART_EN
            rst_marker <= restart;
`endif
        end else if (dpcm_ready) begin
            dpcm_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dpcm_dc_sched.sv
// tb_dpcm_dc_sched: randomized bench with an MCU-order reference model for dpcm_dc_sched.
module tb_dpcm_dc_sched;
    localparam int DW = 12, YP = 4, NM = 2, RI = 1, PER = YP + 2, TOT = NM * PER;

    logic clk = 0, rst = 1, start = 0;
    logic [DW-1:0] y_dc = '0, cb_dc = '0, cr_dc = '0;
    logic y_valid = 0, cb_valid = 0, cr_valid = 0, dpcm_ready = 1;
    logic y_ready, cb_ready, cr_ready, dpcm_valid, dpcm_last, busy;
    logic [DW:0] dpcm_out;
    logic [1:0] dpcm_mode;
`ifdef DPCM_RESTART_EN
    logic rst_marker;
`endif

    dpcm_dc_sched #(
        .DW(DW), .Y_PER_MCU(YP), .NUM_MCU(NM)
`ifdef DPCM_RESTART_EN
        , .RST_INTERVAL(RI)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .y_dc(y_dc), .y_valid(y_valid), .y_ready(y_ready),
        .cb_dc(cb_dc), .cb_valid(cb_valid), .cb_ready(cb_ready),
        .cr_dc(cr_dc), .cr_valid(cr_valid), .cr_ready(cr_ready),
        .dpcm_out(dpcm_out), .dpcm_mode(dpcm_mode), .dpcm_valid(dpcm_valid),
        .dpcm_ready(dpcm_ready), .dpcm_last(dpcm_last), .busy(busy)
`ifdef DPCM_RESTART_EN
        , .rst_marker(rst_marker)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int diff; int mode; bit last; bit mark;} out_t;
    out_t exp_q[$];
    int y_q[$], cb_q[$], cr_q[$], got[$];
    int pred[3];
    int acc_cnt = 0, stall_left = 0, checks = 0, failures = 0;
    bit m_busy = 0, start_req = 0, rand_valid = 0, rand_ready = 0, mid_start = 0;
    bit hold_v = 0;
    int hold_out, hold_mode;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int comp_of(input int n);
        int p = n % PER;
        return p < YP ? 0 : (p == YP ? 1 : 2);
    endfunction

    function automatic int rnd_dc();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        m_busy = 0;
        acc_cnt = 0;
        hold_v = 0;
        for (int i = 0; i < 3; i++) pred[i] = 0;
    endtask

    task automatic fill_random();
        y_q.delete(); cb_q.delete(); cr_q.delete();
        for (int i = 0; i < NM * YP; i++) y_q.push_back(rnd_dc());
        for (int i = 0; i < NM; i++) begin
            cb_q.push_back(rnd_dc());
            cr_q.push_back(rnd_dc());
        end
    endtask

    // one clock: check at negedge, update model, then drive after posedge
    task automatic step();
        int c, ac, dcv, mcu;
        bit room, was_busy;
        out_t e;
        @(negedge clk);
        was_busy = m_busy;
        c = comp_of(acc_cnt);
        room = !dpcm_valid || dpcm_ready;
        chk("busy", busy, m_busy);
        chk("y_ready", y_ready, m_busy && c == 0 && room);
        chk("cb_ready", cb_ready, m_busy && c == 1 && room);
        chk("cr_ready", cr_ready, m_busy && c == 2 && room);
        if (hold_v) begin
            chk("hold_valid", dpcm_valid, 1);
            chk("hold_out", int'($signed(dpcm_out)), hold_out);
            chk("hold_mode", dpcm_mode, hold_mode);
        end
        hold_v = dpcm_valid && !dpcm_ready;
        hold_out = int'($signed(dpcm_out));
        hold_mode = int'(dpcm_mode);
        if (dpcm_valid && dpcm_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: got %0d expected no output", int'($signed(dpcm_out)));
            end else begin
                e = exp_q.pop_front();
                chk("dpcm_out", int'($signed(dpcm_out)), e.diff);
                chk("dpcm_mode", dpcm_mode, e.mode);
                chk("dpcm_last", dpcm_last, e.last);
`ifdef DPCM_RESTART_EN
                chk("rst_marker", rst_marker, e.mark);
`endif
                got.push_back(int'($signed(dpcm_out)));
            end
        end
        if ((y_valid && y_ready) || (cb_valid && cb_ready) || (cr_valid && cr_ready)) begin
            ac = (y_valid && y_ready) ? 0 : (cb_valid && cb_ready) ? 1 : 2;
            dcv = 0;
            if (ac == 0 && y_q.size() > 0) dcv = y_q.pop_front();
            if (ac == 1 && cb_q.size() > 0) dcv = cb_q.pop_front();
            if (ac == 2 && cr_q.size() > 0) dcv = cr_q.pop_front();
            mcu = acc_cnt / PER;
            e.diff = dcv - pred[ac];
            pred[ac] = dcv;
            e.mode = ac == 0 ? 1 : ac == 1 ? 3 : 2;
            e.last = ac == 2 && mcu == NM - 1;
            e.mark = 0;
`ifdef DPCM_RESTART_EN
            if (ac == 2 && (mcu + 1) % RI == 0 && mcu != NM - 1) begin
                e.mark = 1;
                for (int i = 0; i < 3; i++) pred[i] = 0;
            end
`endif
            exp_q.push_back(e);
            acc_cnt++;
            if (acc_cnt == TOT) m_busy = 0;
        end
        if (start && !was_busy) begin
            m_busy = 1;
            acc_cnt = 0;
            for (int i = 0; i < 3; i++) pred[i] = 0;
        end
        @(posedge clk);
        #1;
        start = start_req;
        start_req = 0;
        dpcm_ready = stall_left > 0 ? 1'b0 : rand_ready ? ($urandom % 3 != 0) : 1'b1;
        if (stall_left > 0) stall_left--;
        y_valid = y_q.size() > 0 && (!rand_valid || $urandom % 3 != 0);
        cb_valid = cb_q.size() > 0 && (!rand_valid || $urandom % 3 != 0);
        cr_valid = cr_q.size() > 0 && (!rand_valid || $urandom % 3 != 0);
        y_dc = DW'($urandom);
        cb_dc = DW'($urandom);
        cr_dc = DW'($urandom);
        if (y_q.size() > 0) y_dc = DW'(y_q[0]);
        if (cb_q.size() > 0) cb_dc = DW'(cb_q[0]);
        if (cr_q.size() > 0) cr_dc = DW'(cr_q[0]);
    endtask

    task automatic run_frame(input int budget, input int stall_at, output int n);
        n = 0;
        start_req = 1;
        step();
        step();
        while ((m_busy || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
            if (stall_at >= 0 && got.size() == stall_at) begin
                stall_left = 5;
                stall_at = -1;
            end
            if (mid_start && acc_cnt < TOT - PER && $urandom % 8 == 0) start_req = 1;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got %0d cycles expected under %0d", n, budget);
        end
        step();
        chk("drained_valid", dpcm_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_valid", dpcm_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", int'(dpcm_out), 0);
        chk("rst_mode", dpcm_mode, 0);
        chk("rst_last", dpcm_last, 0);
        chk("rst_y_ready", y_ready, 0);
        #1;
        rst = 0;
        clear_model();
    endtask

    initial begin
        int n;
        clear_model();
        #3;
        chk("init_valid", dpcm_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_out", int'(dpcm_out), 0);
        #9;
        rst = 0;

        // directed frame, all sources valid, no backpressure
        got.delete();
        y_q = '{100, 104, 98, 98, 10, 20, 30, 40};
        cb_q = '{50, 45};
        cr_q = '{60, 70};
        run_frame(100, -1, n);
        chk("thru_cycles", n, 13);
        chk("a_count", got.size(), TOT);
        if (got.size() == TOT) begin
            chk("a_y0", got[0], 100);
            chk("a_y1", got[1], 4);
            chk("a_y2", got[2], -6);
            chk("a_y3", got[3], 0);
            chk("a_cb0", got[4], 50);
            chk("a_cr0", got[5], 60);
`ifdef DPCM_RESTART_EN
            chk("a_y4", got[6], 10);
            chk("a_cb1", got[10], 45);
            chk("a_cr1", got[11], 70);
`else
            chk("a_y4", got[6], -88);
            chk("a_cb1", got[10], -5);
            chk("a_cr1", got[11], 10);
`endif
        end

        // extreme values: full 13-bit swing without wrap
        got.delete();
        y_q = '{-2048, 2047, 2047, -2048, 5, 5, 5, 5};
        cb_q = '{0, 0};
        cr_q = '{0, 0};
        run_frame(100, -1, n);
        if (got.size() == TOT) begin
            chk("ext_y0", got[0], -2048);
            chk("ext_up", got[1], 4095);
            chk("ext_down", got[3], -4095);
        end

        // 5-cycle backpressure mid-Y
        got.delete();
        fill_random();
        run_frame(100, 2, n);
        chk("stall_cycles", n, 18);
        chk("stall_count", got.size(), TOT);

        // reset after three Y accepts, then a fresh frame
        fill_random();
        start_req = 1;
        step();
        step();
        for (int k = 0; k < 50 && acc_cnt < 3; k++) step();
        chk("pre_reset_acc", acc_cnt, 3);
        do_reset();
        got.delete();
        fill_random();
        y_q[0] = 777;
        y_q[1] = -300;
        run_frame(100, -1, n);
        if (got.size() == TOT) begin
            chk("rst_first_y", got[0], 777);
            chk("rst_second_y", got[1], -1077);
        end

        // randomized valids, ready and stray starts
        rand_valid = 1;
        rand_ready = 1;
        mid_start = 1;
        for (int f = 0; f < 30; f++) begin
            fill_random();
            run_frame(400, -1, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dpcm_dc_sched.md
Name: dpcm_dc_sched

Overview:
- Sequences DC coefficients from three component sources (Y, Cb, Cr) through one shared DPCM datapath in fixed MCU order (Y_PER_MCU x Y, then Cb, then Cr).
- Keeps one predictor per component.
- Emits tagged differential DC values with valid/ready backpressure.
- Sits between the DCT/quantizer DC outputs and the entropy encoder in the EPU pipeline.

Parameters:
- DW, 12, input DC width (signed two's complement).
- Y_PER_MCU, 4, Y blocks per MCU (1..4).
- NUM_MCU, 64, MCUs per frame.
- RST_INTERVAL, 8, MCUs between predictor restarts (only with DPCM_RESTART_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
- y_dc  in  DW  Y DC coefficient.
- y_valid  in  1  y_dc valid.
- y_ready  out  1  Y accepted this cycle.
- cb_dc  in  DW  Cb DC coefficient.
- cb_valid  in  1  cb_dc valid.
- cb_ready  out  1  Cb accepted this cycle.
- cr_dc  in  DW  Cr DC coefficient.
- cr_valid  in  1  cr_dc valid.
- cr_ready  out  1  Cr accepted this cycle.
- dpcm_out  out  DW+1  differential DC, signed.
- dpcm_mode  out  2  component tag: 01 Y, 10 Cr, 11 Cb.
- dpcm_valid  out  1  output register holds data.
- dpcm_ready  in  1  downstream accepts.
- dpcm_last  out  1  qualifies the final Cr of the frame.
- busy  out  1  high from the cycle after start until frame completion.

Behaviour:
- Reset: all outputs 0, all predictors 0, counters 0, state IDLE.
- FSM states: IDLE, RUN_Y, RUN_CB, RUN_CR.
- IDLE -> RUN_Y on start. The same edge clears all three predictors and both counters.
- RUN_Y: accepts y only. After Y_PER_MCU accepts -> RUN_CB. y_cnt (0..Y_PER_MCU-1) wraps to 0.
- RUN_CB -> RUN_CR after one Cb accept.
- RUN_CR -> RUN_Y after one Cr accept. On the Cr accept where mcu_cnt==NUM_MCU-1, go to IDLE instead.
- mcu_cnt increments on each Cr accept.
- Handshake: only the ready of the scheduled component can be high. Its ready = state match AND (!dpcm_valid OR dpcm_ready). Valids of other components are ignored and their data held. Ready is combinational.
- Accept: the scheduled valid and ready are both high.
- On accept, the same edge performs:
  - dpcm_out <= sext(dc) - sext(pred[comp]), computed in DW+1 bits with no saturation.
  - pred[comp] <= dc; dpcm_mode <= tag; dpcm_valid <= 1.
  - dpcm_last <= (comp==Cr AND mcu_cnt==NUM_MCU-1).
- Latency: 1 cycle from accept to dpcm_valid.
- First block of each component per frame: diff = dc - 0 = dc.
- dpcm_valid clears on a dpcm_ready cycle with no new accept. A simultaneous drain and accept reloads the register, giving full throughput of one per cycle.
- Stall: while dpcm_valid and !dpcm_ready, all readies are 0 and output fields are held stable.
- busy falls on the cycle after the last accept. The final output may still be pending; dpcm_last stays with its data until drained.
- start while busy: ignored.
- rst mid-frame: immediate return to IDLE; the pending output is discarded.

Optional Feature:
- Macro: DPCM_RESTART_EN.
- Defined: after every RST_INTERVAL completed MCUs (Cr accept with (mcu_cnt+1) % RST_INTERVAL == 0, not the final MCU), all predictors clear on that edge. A 1-bit output rst_marker is added; it is registered with and qualified by dpcm_valid on that Cr output.
- Undefined: no restart logic, no rst_marker port; predictors clear only at start.

Decomposition:
- Package epu_dpcm_pkg:
  - MODE_Y=2'b01, MODE_CR=2'b10, MODE_CB=2'b11.
  - State enum sched_state_t {IDLE, RUN_Y, RUN_CB, RUN_CR}.
  - Typedef dc_t (signed DW) and dc_diff_t (signed DW+1).
- Sub-module dpcm_pred_bank:
  - Holds the three predictor registers plus the subtractor.
  - Inputs: comp select, dc, update strobe, clear.
  - Output: combinational diff.
- The scheduler keeps the FSM, counters, handshake and output register.

Test Plan:
- Single frame, NUM_MCU=2, Y_PER_MCU=4, all valids high, dpcm_ready=1:
  - Y sequence 100,104,98,98,... -> outputs 100,4,-6,0.
  - Cb 50 then 45 -> 50, -5.
  - Cr 60 -> 60.
  - Tags follow Y Y Y Y Cb Cr; dpcm_last only on the 12th output.
- Extreme values: y=-2048 then 2047 -> 13-bit diff +4095; reverse order -> -4095; no wrap.
- Backpressure: dpcm_ready low for 5 cycles mid-Y -> all readies 0, outputs held. On release, one output per cycle resumes with no loss or duplication.
- Wrong-component valids: cr_valid and cb_valid high during RUN_Y -> cr_ready and cb_ready stay 0; Cr data is taken only in RUN_CR.
- Reset mid-frame after 3 Y accepts, then start -> predictors 0; first Y output equals the raw dc; busy high again.
- DPCM_RESTART_EN with RST_INTERVAL=1, NUM_MCU=3 -> first Y/Cb/Cr of every MCU equals raw dc; rst_marker on the Cr outputs of MCU 0 and MCU 1, not MCU 2.
